// File: rtl/bus_read_arbiter.sv
// Round-robin read-fill arbiter: icache (m0) and dcache (m1) share one slave.
// A grant is held for a full cacheline burst of BURST_LEN acks.
module bus_read_arbiter #(
  parameter int ADDR_SIZE_BITS = 32,
  parameter int DATA_SIZE_BITS = 32,
  parameter int BURST_LEN      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_SIZE_BITS-1:0] m0_bus_addr_read,
  input  logic                      m0_bus_stbr,
  output logic                      m0_bus_ackr,
  output logic [DATA_SIZE_BITS-1:0] m0_bus_data_read,
  input  logic [ADDR_SIZE_BITS-1:0] m1_bus_addr_read,
  input  logic                      m1_bus_stbr,
  output logic                      m1_bus_ackr,
  output logic [DATA_SIZE_BITS-1:0] m1_bus_data_read,
  output logic [ADDR_SIZE_BITS-1:0] bus_addr_read,
  output logic                      bus_stbr,
  input  logic                      bus_ackr,
  input  logic [DATA_SIZE_BITS-1:0] bus_data_read,
  output logic [1:0]                grant
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                w_last_nxt;
  logic [CW-1:0]       r_beat_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [CW-1:0]       w_cnt_inc;
  logic                w_granted;
  logic                w_sel_stbr;
  logic [ADDR_SIZE_BITS-1:0] w_sel_addr;
  logic                w_beat;

  // Data fans out to both masters; the ack alone qualifies it.
  assign m0_bus_data_read = bus_data_read;
  assign m1_bus_data_read = bus_data_read;

  // Select the granted master and form the slave-side outputs.
  always_comb begin
    w_granted  = (r_state != IDLE);
    w_sel_stbr = (r_state == GRANT1) ? m1_bus_stbr
                                     : m0_bus_stbr;
    w_sel_addr = (r_state == GRANT1) ? m1_bus_addr_read
                                     : m0_bus_addr_read;
    w_beat     = w_granted & bus_ackr & w_sel_stbr;
    w_cnt_inc  = r_beat_cnt + CW'(1);

    bus_stbr      = ~reset & w_granted & w_sel_stbr;
    bus_addr_read = (~reset & w_granted) ? w_sel_addr : '0;
    m0_bus_ackr   = ~reset & (r_state == GRANT0)
                  & bus_ackr & m0_bus_stbr;
    m1_bus_ackr   = ~reset & (r_state == GRANT1)
                  & bus_ackr & m1_bus_stbr;
    grant         = reset ? 2'b00
                  : {r_state == GRANT1, r_state == GRANT0};
  end

  // Arbitration decision, beat counting and burst end/abort.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last_grant;
    w_cnt_nxt   = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (m0_bus_stbr && (!m1_bus_stbr || r_last_grant)) begin
          w_state_nxt = GRANT0;
          w_last_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else if (m1_bus_stbr) begin
          w_state_nxt = GRANT1;
          w_last_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      GRANT0, GRANT1: begin
        if (w_beat) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == LP_LAST) begin
            w_state_nxt = IDLE;
          end
        end else if (!w_sel_stbr && r_beat_cnt == '0) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State registers; last_grant starts at 1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
      r_beat_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_bus_read_arbiter.sv
// Directed bench for bus_read_arbiter.
// Bench-side master and slave models; expectations hand-derived.
module tb_bus_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_bus_addr_read;
  logic          m0_bus_stbr;
  logic          m0_bus_ackr;
  logic [DW-1:0] m0_bus_data_read;
  logic [AW-1:0] m1_bus_addr_read;
  logic          m1_bus_stbr;
  logic          m1_bus_ackr;
  logic [DW-1:0] m1_bus_data_read;
  logic [AW-1:0] bus_addr_read;
  logic          bus_stbr;
  logic          bus_ackr;
  logic [DW-1:0] bus_data_read;
  logic [1:0]    grant;

  bus_read_arbiter #(
    .ADDR_SIZE_BITS(AW),
    .DATA_SIZE_BITS(DW),
    .BURST_LEN(BL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .m0_bus_addr_read(m0_bus_addr_read),
    .m0_bus_stbr(m0_bus_stbr),
    .m0_bus_ackr(m0_bus_ackr),
    .m0_bus_data_read(m0_bus_data_read),
    .m1_bus_addr_read(m1_bus_addr_read),
    .m1_bus_stbr(m1_bus_stbr),
    .m1_bus_ackr(m1_bus_ackr),
    .m1_bus_data_read(m1_bus_data_read),
    .bus_addr_read(bus_addr_read),
    .bus_stbr(bus_stbr),
    .bus_ackr(bus_ackr),
    .bus_data_read(bus_data_read),
    .grant(grant)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];

  logic        m0_req, m1_req, m0_cont, m1_cont;
  int          m0_cnt, m1_cnt;
  logic [31:0] m0_base, m1_base;
  int          slv_mode;
  logic        force_ack, tog;

  logic [1:0]  o_grant;
  logic        o_stbr, o_m0ack, o_m1ack;
  logic [31:0] o_addr, o_m0data, o_m1data;

  int checks = 0;
  int errors = 0;

  task automatic step();
    m0_bus_stbr      = m0_req;
    m0_bus_addr_read = m0_base + 32'(4 * m0_cnt);
    m1_bus_stbr      = m1_req;
    m1_bus_addr_read = m1_base + 32'(4 * m1_cnt);
    #1;
    bus_data_read = mem[bus_addr_read[5:2]];
    bus_ackr = force_ack
             | (bus_stbr & ((slv_mode == 1)
                | ((slv_mode == 2) & tog)));
    #1;
    o_grant  = grant;
    o_stbr   = bus_stbr;
    o_addr   = bus_addr_read;
    o_m0ack  = m0_bus_ackr;
    o_m1ack  = m1_bus_ackr;
    o_m0data = m0_bus_data_read;
    o_m1data = m1_bus_data_read;
    @(posedge clk);
    #1;
    if (o_stbr) tog = ~tog;
    if (o_m0ack) begin
      m0_cnt++;
      if (m0_cnt == BL) begin
        m0_cnt = 0;
        m0_req = m0_cont;
      end
    end
    if (o_m1ack) begin
      m1_cnt++;
      if (m1_cnt == BL) begin
        m1_cnt = 0;
        m1_req = m1_cont;
      end
    end
  endtask

  task automatic clear_models();
    m0_req = 0; m1_req = 0;
    m0_cont = 0; m1_cont = 0;
    m0_cnt = 0; m1_cnt = 0;
    m0_base = 32'h0; m1_base = 32'h10;
    slv_mode = 0; force_ack = 0; tog = 0;
  endtask

  task automatic apply_reset();
    clear_models();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_models();
    reset = 1;
    m0_req = 1;
    force_ack = 1;
    step();
    checks++;
    if (o_grant !== 2'b00 || o_stbr !== 1'b0) begin
      errors++;
      $display("FAIL rst_in: grant=%b stbr=%b want 00 0",
               o_grant, o_stbr);
    end
    checks++;
    if (o_m0ack !== 1'b0 || o_m1ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ack: m0=%b m1=%b want 0 0",
               o_m0ack, o_m1ack);
    end
    clear_models();
    step();
    reset = 0;
    step();
    checks++;
    if (o_grant !== 2'b00 || o_stbr !== 1'b0
        || o_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_out: grant=%b stbr=%b addr=%h",
               o_grant, o_stbr, o_addr);
    end
    checks++;
    if (dut.r_last_grant !== 1'b1
        || dut.r_beat_cnt !== 3'd0) begin
      errors++;
      $display("FAIL rst_regs: last=%b cnt=%0d want 1 0",
               dut.r_last_grant, dut.r_beat_cnt);
    end
  endtask

  task automatic test_single();
    int acks, m1hits, guard;
    apply_reset();
    slv_mode = 2;
    m0_req = 1;
    step();
    checks++;
    if (o_grant !== 2'b00 || o_stbr !== 1'b0) begin
      errors++;
      $display("FAIL t1_lat: grant=%b stbr=%b want 00 0",
               o_grant, o_stbr);
    end
    acks = 0; m1hits = 0; guard = 0;
    while (acks < 4 && guard < 30) begin
      step();
      if (guard == 0) begin
        checks++;
        if (o_grant !== 2'b01 || o_stbr !== 1'b1) begin
          errors++;
          $display("FAIL t1_grant: grant=%b stbr=%b want 01 1",
                   o_grant, o_stbr);
        end
      end
      guard++;
      if (o_m1ack) m1hits++;
      if (o_m0ack) begin
        checks++;
        if (o_m0data !== mem[acks]) begin
          errors++;
          $display("FAIL t1_data%0d: got %h want %h",
                   acks, o_m0data, mem[acks]);
        end
        acks++;
      end
    end
    checks++;
    if (acks != 4) begin
      errors++;
      $display("FAIL t1_acks: got %0d want 4", acks);
    end
    step();
    if (o_m1ack) m1hits++;
    checks++;
    if (o_grant !== 2'b00) begin
      errors++;
      $display("FAIL t1_end: grant=%b want 00", o_grant);
    end
    checks++;
    if (m1hits != 0) begin
      errors++;
      $display("FAIL t1_m1ack: got %0d want 0", m1hits);
    end
  endtask

  task automatic test_tie();
    int acks, m1hits, guard;
    logic [31:0] exp;
    apply_reset();
    slv_mode = 2;
    m0_req = 1;
    m1_req = 1;
    step();
    acks = 0; m1hits = 0; guard = 0;
    while (acks < 4 && guard < 30) begin
      step();
      if (guard == 0) begin
        checks++;
        if (o_grant !== 2'b01) begin
          errors++;
          $display("FAIL t2_first: grant=%b want 01", o_grant);
        end
      end
      guard++;
      if (o_m1ack) m1hits++;
      if (o_m0ack) begin
        checks++;
        if (o_m0data !== mem[acks]) begin
          errors++;
          $display("FAIL t2_m0data%0d: got %h want %h",
                   acks, o_m0data, mem[acks]);
        end
        acks++;
      end
    end
    checks++;
    if (acks != 4 || m1hits != 0) begin
      errors++;
      $display("FAIL t2_m0burst: acks=%0d m1=%0d want 4 0",
               acks, m1hits);
    end
    step();
    checks++;
    if (o_grant !== 2'b00) begin
      errors++;
      $display("FAIL t2_bubble: grant=%b want 00", o_grant);
    end
    acks = 0; guard = 0;
    while (acks < 4 && guard < 30) begin
      step();
      if (guard == 0) begin
        checks++;
        if (o_grant !== 2'b10 || o_addr !== 32'h10) begin
          errors++;
          $display("FAIL t2_second: grant=%b addr=%h want 10 10",
                   o_grant, o_addr);
        end
      end
      guard++;
      if (o_m1ack) begin
        exp = 32'h4444_4444 + 32'(acks) * 32'h1111_1111;
        checks++;
        if (o_m1data !== exp) begin
          errors++;
          $display("FAIL t2_m1data%0d: got %h want %h",
                   acks, o_m1data, exp);
        end
        acks++;
      end
    end
    checks++;
    if (acks != 4) begin
      errors++;
      $display("FAIL t2_m1acks: got %0d want 4", acks);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp [3];
    logic [1:0] prev;
    int nb, acks, idle;
    exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01;
    apply_reset();
    slv_mode = 1;
    m0_req = 1; m1_req = 1;
    m0_cont = 1; m1_cont = 1;
    nb = 0; acks = 0; idle = 0; prev = 2'b00;
    for (int i = 0; i < 80 && nb < 3; i++) begin
      step();
      if (o_grant != 2'b00 && prev == 2'b00) begin
        checks++;
        if (o_grant !== exp[nb]) begin
          errors++;
          $display("FAIL t3_seq%0d: grant=%b want %b",
                   nb, o_grant, exp[nb]);
        end
        if (nb > 0) begin
          checks++;
          if (idle != 1) begin
            errors++;
            $display("FAIL t3_idle%0d: got %0d want 1",
                     nb, idle);
          end
        end
        acks = 0;
      end
      if (o_m0ack || o_m1ack) acks++;
      if (o_grant == 2'b00 && prev != 2'b00) begin
        checks++;
        if (acks != 4) begin
          errors++;
          $display("FAIL t3_len%0d: got %0d want 4", nb, acks);
        end
        nb++;
        idle = 0;
      end
      if (o_grant == 2'b00) idle++;
      prev = o_grant;
    end
    checks++;
    if (nb != 3) begin
      errors++;
      $display("FAIL t3_bursts: got %0d want 3", nb);
    end
  endtask

  task automatic test_withdraw();
    apply_reset();
    slv_mode = 0;
    m1_req = 1;
    step();
    m0_req = 1;
    step();
    checks++;
    if (o_grant !== 2'b10 || o_addr !== 32'h10) begin
      errors++;
      $display("FAIL t4_grant: grant=%b addr=%h want 10 10",
               o_grant, o_addr);
    end
    m1_req = 0;
    step();
    checks++;
    if (o_stbr !== 1'b0 || o_m0ack !== 1'b0) begin
      errors++;
      $display("FAIL t4_drop: stbr=%b m0ack=%b want 0 0",
               o_stbr, o_m0ack);
    end
    step();
    checks++;
    if (o_grant !== 2'b00) begin
      errors++;
      $display("FAIL t4_idle: grant=%b want 00", o_grant);
    end
    step();
    checks++;
    if (o_grant !== 2'b01 || o_addr !== 32'h0
        || o_stbr !== 1'b1) begin
      errors++;
      $display("FAIL t4_m0: grant=%b addr=%h stbr=%b",
               o_grant, o_addr, o_stbr);
    end
  endtask

  task automatic test_spurious();
    apply_reset();
    force_ack = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (o_m0ack !== 1'b0 || o_m1ack !== 1'b0
          || o_grant !== 2'b00) begin
        errors++;
        $display("FAIL t5_idle: m0=%b m1=%b grant=%b",
                 o_m0ack, o_m1ack, o_grant);
      end
    end
    force_ack = 0;
    slv_mode = 1;
    m0_req = 1;
    step();
    step();
    step();
    checks++;
    if (dut.r_beat_cnt !== 3'd2) begin
      errors++;
      $display("FAIL t5_cnt2: got %0d want 2", dut.r_beat_cnt);
    end
    m0_req = 0;
    force_ack = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (o_m0ack !== 1'b0 || o_m1ack !== 1'b0
          || o_stbr !== 1'b0 || o_grant !== 2'b01) begin
        errors++;
        $display("FAIL t5_gap: m0=%b m1=%b stbr=%b grant=%b",
                 o_m0ack, o_m1ack, o_stbr, o_grant);
      end
    end
    checks++;
    if (dut.r_beat_cnt !== 3'd2) begin
      errors++;
      $display("FAIL t5_hold: got %0d want 2", dut.r_beat_cnt);
    end
    m0_req = 1;
    force_ack = 0;
    for (int k = 2; k < 4; k++) begin
      step();
      checks++;
      if (o_m0ack !== 1'b1 || o_m0data !== mem[k]) begin
        errors++;
        $display("FAIL t5_beat%0d: ack=%b data=%h want 1 %h",
                 k, o_m0ack, o_m0data, mem[k]);
      end
    end
    step();
    checks++;
    if (o_grant !== 2'b00) begin
      errors++;
      $display("FAIL t5_end: grant=%b want 00", o_grant);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    apply_reset();
    slv_mode = 1;
    m0_req = 1;
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    clear_models();
    checks++;
    if (dut.r_beat_cnt !== 3'd0) begin
      errors++;
      $display("FAIL t6_cnt: got %0d want 0", dut.r_beat_cnt);
    end
    slv_mode = 1;
    m1_req = 1;
    step();
    checks++;
    if (o_grant !== 2'b00 || o_stbr !== 1'b0) begin
      errors++;
      $display("FAIL t6_idle: grant=%b stbr=%b want 00 0",
               o_grant, o_stbr);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      exp = 32'h4444_4444 + 32'(k) * 32'h1111_1111;
      checks++;
      if (o_grant !== 2'b10 || o_m1ack !== 1'b1
          || o_m1data !== exp) begin
        errors++;
        $display("FAIL t6_m1_%0d: g=%b ack=%b data=%h want %h",
                 k, o_grant, o_m1ack, o_m1data, exp);
      end
    end
    step();
    checks++;
    if (o_grant !== 2'b00) begin
      errors++;
      $display("FAIL t6_end: grant=%b want 00", o_grant);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'(i) * 32'h1111_1111;
    end
    clear_models();
    reset = 1;
    bus_ackr = 0;
    bus_data_read = '0;
    m0_bus_stbr = 0;
    m1_bus_stbr = 0;
    m0_bus_addr_read = '0;
    m1_bus_addr_read = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_withdraw();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_read_arbiter.md
Name: bus_read_arbiter

Overview:
Two-master, one-slave arbiter for the cache read-fill bus (bus_addr_read / bus_data_read / bus_stbr / bus_ackr).
- It sits directly downstream of the instruction cache (master 0) and the data cache (master 1), between them and the memory/bus slave.
- It grants one cache at a time and holds the grant for a whole cacheline refill.
- Arbitration between the two caches is round-robin.

Parameters:
ADDR_SIZE_BITS, 32, width of read address
DATA_SIZE_BITS, 32, width of one bus beat
BURST_LEN, 4, acks per granted refill (= cache ENTRIES_PER_CACHELINE); must be >= 1

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
m0_bus_addr_read  in  ADDR_SIZE_BITS  master 0 (icache) read address
m0_bus_stbr  in  1  master 0 read strobe, held until ack
m0_bus_ackr  out  1  master 0 ack, one-cycle pulse
m0_bus_data_read  out  DATA_SIZE_BITS  master 0 read data
m1_bus_addr_read  in  ADDR_SIZE_BITS  master 1 (dcache) read address
m1_bus_stbr  in  1  master 1 read strobe
m1_bus_ackr  out  1  master 1 ack
m1_bus_data_read  out  DATA_SIZE_BITS  master 1 read data
bus_addr_read  out  ADDR_SIZE_BITS  slave address
bus_stbr  out  1  slave strobe
bus_ackr  in  1  slave ack, valid in the cycle bus_data_read is valid
bus_data_read  in  DATA_SIZE_BITS  slave data
grant  out  2  one-hot current grant; 00 when idle

Behaviour:
- States: IDLE, GRANT0, GRANT1. Also a last_grant register (1 bit) and beat_cnt (clog2(BURST_LEN+1) bits).
- Reset values:
  - state=IDLE, last_grant=1 (so master 0 wins the first tie), beat_cnt=0.
  - grant=00, bus_stbr=0, bus_addr_read=0.
  - m0_bus_ackr=0 and m1_bus_ackr=0.
- Reset mid-burst aborts the burst immediately: next state IDLE, all outputs at their reset values.
- Transitions out of IDLE (decision registered; bus_stbr=0 while IDLE):
  - only m0_bus_stbr: GRANT0.
  - only m1_bus_stbr: GRANT1.
  - both: grant the master != last_grant.
  - On entry to GRANTx: last_grant<=x, beat_cnt<=0.
- Arbitration latency: 1 cycle. A strobe seen in cycle N gives bus_stbr=1 in cycle N+1.
- In GRANTx, the datapath is combinational:
  - bus_addr_read = mx_bus_addr_read; bus_stbr = mx_bus_stbr.
  - mx_bus_ackr = bus_ackr & mx_bus_stbr. The ungranted master's ack is always 0.
  - Both mx_bus_data_read are driven from bus_data_read unconditionally; ack gating qualifies the data.
- Each cycle with bus_ackr & mx_bus_stbr increments beat_cnt.
- End of burst: the ack that makes beat_cnt == BURST_LEN moves to IDLE next cycle. This gives a 1-cycle bubble before the next arbitration.
- Abort: in GRANTx with mx_bus_stbr=0 and beat_cnt==0, the request was withdrawn (e.g. pipeline clear). Go to IDLE next cycle.
- Gaps: mx_bus_stbr=0 with beat_cnt>0 is a gap between beats. The grant is held and bus_stbr=0.
- Spurious ack (bus_ackr=1 in IDLE, or while the granted strobe is low) is ignored: not counted, not forwarded.
- Strobe changes by the ungranted master during a burst do not affect the bus. That request is served after the current burst.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1 per burst.
- grant mirrors state: GRANT0=01, GRANT1=10, IDLE=00.

Test Plan:
1. Reset, then m0 strobes addr 0x0000_0000 for 4 beats with a slave acking every other cycle:
   - grant=01 one cycle after the first strobe.
   - m0 receives 4 acks with mem[0..3].
   - grant=00 the cycle after the 4th ack.
   - m1_bus_ackr never 1.
2. m0 and m1 both strobe in the same cycle right after reset:
   - m0 is granted first, completes 4 beats.
   - IDLE for 1 cycle, then m1 is granted for addr 0x0000_0010 and gets data 0x4444_4444..0x7777_7777.
3. Both strobe continuously for 3 bursts:
   - grant sequence is 01,10,01.
   - Each burst is exactly 4 acks with a 1-cycle IDLE between bursts.
4. m1 is granted and drops its strobe before any ack:
   - arbiter returns to IDLE next cycle.
   - A pending m0 request is granted the following cycle.
5. Slave asserts bus_ackr while IDLE, and again while the granted strobe is low mid-burst (beat_cnt=2):
   - no mx_bus_ackr pulses.
   - beat_cnt stays 2; the burst completes after 2 further real acks.
6. Reset asserted during beat 2 of an m0 burst:
   - next cycle grant=00, bus_stbr=0, beat_cnt=0.
   - A fresh m1 request afterwards is granted normally.
